// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a single outstanding bus request, a
// decode-facing output register and a one-entry skid buffer. Branch redirects
// honour the delay slot: the instruction after a taken branch always reaches
// decode.
//
// Optional feature macro: FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   ireq_valid/ireq_addr   instruction-bus request (word aligned)
//   iresp_addr_ok          bus accepted the request this cycle
//   iresp_data_ok/_data    bus returns an instruction word this cycle
//   d_valid/d_pc/d_instr   decode-stage input register
//   d_stall                decode stall; output register holds
//   redirect_valid/_pc     taken branch target, sampled on d_valid && !d_stall
//   perf_fetch_cnt         (FETCH_PERF_EN) count of data_ok cycles
//   perf_stall_cnt         (FETCH_PERF_EN) count of d_valid && d_stall cycles
module fetch_stage (
  input  logic        clk,
  input  logic        resetn,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        d_valid,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  input  logic        d_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q;
  logic [31:0] req_pc;
  logic        buf_valid;
  logic [31:0] buf_pc, buf_instr;
  logic        redir_pend;
  logic [31:0] redir_pc;

  logic        consume, req_fire, data_fire, to_buf;
  logic        redir_take, redir_defer;
  logic [31:0] data_pc;

  always_comb begin
    consume   = d_valid && !d_stall;
    req_fire  = (state == S_REQ) && iresp_addr_ok;
    // Only a response to our own outstanding request is accepted; a stray
    // data_ok (e.g. from a request issued before reset) is ignored.
    data_fire = iresp_data_ok && ((state == S_WAIT) || req_fire);
    data_pc   = (state == S_WAIT) ? req_pc : pc_q;
    to_buf    = data_fire && d_valid && d_stall;
    redir_take = consume && redirect_valid;
    // Delay slot not yet requested: fetch it first, redirect afterwards.
    // If it is being accepted this very cycle the redirect can apply at once.
    redir_defer = redir_take && (pc_q == d_pc + 32'd4) && !req_fire;

    state_nxt = state;
    unique case (state)
      S_REQ:   if (req_fire) state_nxt = data_fire ? (to_buf ? S_FULL : S_REQ) : S_WAIT;
      S_WAIT:  if (iresp_data_ok) state_nxt = to_buf ? S_FULL : S_REQ;
      S_FULL:  if (consume) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  // Gated with resetn so no request is shown while reset is held.
  assign ireq_valid = resetn && (state == S_REQ);
  assign ireq_addr  = pc_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_REQ;
      pc_q       <= RESET_PC;
      req_pc     <= '0;
      d_valid    <= 1'b0;
      d_pc       <= '0;
      d_instr    <= '0;
      buf_valid  <= 1'b0;
      buf_pc     <= '0;
      buf_instr  <= '0;
      redir_pend <= 1'b0;
      redir_pc   <= '0;
    end else begin
      state <= state_nxt;

      if (req_fire) begin
        req_pc     <= pc_q;
        redir_pend <= 1'b0;
      end
      if (redir_defer) begin
        redir_pend <= 1'b1;
        redir_pc   <= redirect_pc;
      end

      if (redir_take && !redir_defer)
        pc_q <= redirect_pc;
      else if (req_fire)
        pc_q <= redir_pend ? redir_pc : pc_q + 32'd4;

      if (consume) begin
        if (buf_valid) begin
          d_pc      <= buf_pc;
          d_instr   <= buf_instr;
          buf_valid <= 1'b0;
        end else if (data_fire) begin
          d_pc    <= data_pc;
          d_instr <= iresp_data;
        end else begin
          d_valid <= 1'b0;
        end
      end else if (!d_valid && data_fire) begin
        d_valid <= 1'b1;
        d_pc    <= data_pc;
        d_instr <= iresp_data;
      end else if (to_buf) begin
        buf_valid <= 1'b1;
        buf_pc    <= data_pc;
        buf_instr <= iresp_data;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (iresp_data_ok)      perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (d_valid && d_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: random bus timing, decode stalls and taken
// branches; expected decode stream comes from an architectural pc model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_addr_ok = 1'b0;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        d_valid;
  logic [31:0] d_pc, d_instr;
  logic        d_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk),
    .resetn(resetn),
    .ireq_valid(ireq_valid),
    .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data),
    .d_valid(d_valid),
    .d_pc(d_pc),
    .d_instr(d_instr),
    .d_stall(d_stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int unsigned consumed = 0;

  // knobs
  int unsigned p_addr_ok = 100, min_lat = 0, max_lat = 0, p_stall = 0, p_redir = 0;
  bit bus_en = 0, dec_en = 0, mon_en = 0;

  // bus responder state
  bit          bus_busy = 0, bus_stale = 0;
  logic [31:0] bus_addr = '0;
  int unsigned bus_cnt = 0;

  // architectural decode model
  logic [31:0] exp_q[$];
  logic [31:0] arch_pc = 32'hBFC0_0000;
  logic [31:0] slot_tgt = '0;
  bit          in_slot = 0;

  int unsigned ph_ok[4]    = '{100, 40, 70, 100};
  int unsigned ph_min[4]   = '{0, 0, 1, 0};
  int unsigned ph_max[4]   = '{1, 3, 2, 0};
  int unsigned ph_stall[4] = '{30, 30, 50, 60};
  int unsigned ph_redir[4] = '{20, 25, 30, 40};

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus responder: one outstanding request, latency min_lat..max_lat cycles.
  initial begin
    int unsigned lat;
    forever begin
      @(negedge clk);
      iresp_addr_ok = 1'b0;
      iresp_data_ok = 1'b0;
      iresp_data    = $urandom;
      if (bus_busy) begin
        if (!bus_stale && resetn)
          check("one_outstanding", {31'b0, ireq_valid}, 32'h0);
        if (bus_cnt == 0) begin
          iresp_data_ok = 1'b1;
          iresp_data    = mem(bus_addr);
          bus_busy      = 0;
          bus_stale     = 0;
        end else begin
          bus_cnt = bus_cnt - 1;
        end
      end else if (bus_en && resetn && ireq_valid) begin
        check("ireq_align", ireq_addr & 32'h3, 32'h0);
        if ($urandom_range(99) < p_addr_ok) begin
          iresp_addr_ok = 1'b1;
          lat = $urandom_range(max_lat, min_lat);
          if (lat == 0) begin
            iresp_data_ok = 1'b1;
            iresp_data    = mem(ireq_addr);
          end else begin
            bus_busy = 1;
            bus_addr = ireq_addr;
            bus_cnt  = lat - 1;
          end
        end
      end
    end
  end

  // Decode driver: stalls, taken branches (never in a delay slot), and the
  // expected next pc pushed whenever an instruction is consumed.
  initial begin
    logic [31:0] r;
    forever begin
      @(negedge clk);
      d_stall        = 1'b0;
      redirect_valid = 1'b0;
      r              = $urandom;
      redirect_pc    = r;
      if (dec_en && resetn) begin
        d_stall = ($urandom_range(99) < p_stall);
        if (d_valid && !d_stall) begin
          if (in_slot) begin
            arch_pc = slot_tgt;
            in_slot = 0;
          end else if ($urandom_range(99) < p_redir) begin
            r = $urandom;
            if (r[2:0] == 3'd0) r = 32'hFFFF_FFF8;
            else                r = r & 32'hFFFF_FFFC;
            redirect_valid = 1'b1;
            redirect_pc    = r;
            slot_tgt       = r;
            in_slot        = 1;
            arch_pc        = arch_pc + 32'd4;
          end else begin
            arch_pc = arch_pc + 32'd4;
          end
          exp_q.push_back(arch_pc);
        end else begin
          // must be ignored: not a sampling cycle
          redirect_valid = ($urandom_range(3) == 0);
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every consume, checks stall hold.
  initial begin
    logic [31:0] e, hpc, hin;
    bit hv;
    int unsigned idle;
`ifdef FETCH_PERF_EN
    logic [31:0] m_fetch, m_stall;
    m_fetch = '0;
    m_stall = '0;
`endif
    hv = 0;
    idle = 0;
    hpc = '0;
    hin = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!resetn) begin
        hv = 0;
        idle = 0;
`ifdef FETCH_PERF_EN
        m_fetch = '0;
        m_stall = '0;
`endif
      end else begin
`ifdef FETCH_PERF_EN
        check("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
        check("perf_stall_cnt", perf_stall_cnt, m_stall);
        if (iresp_data_ok)      m_fetch = m_fetch + 32'd1;
        if (d_valid && d_stall) m_stall = m_stall + 32'd1;
`endif
        if (mon_en) begin
          if (hv) begin
            check("hold_valid", {31'b0, d_valid}, 32'h1);
            check("hold_pc", d_pc, hpc);
            check("hold_instr", d_instr, hin);
          end
          if (d_valid && !d_stall) begin
            idle = 0;
            consumed++;
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL scoreboard: consumed pc %h, expected none pending", d_pc);
            end else begin
              e = exp_q.pop_front();
              check("d_pc", d_pc, e);
              check("d_instr", d_instr, mem(e));
            end
          end else begin
            idle++;
            if (idle == 150) begin
              vectors++;
              miscompares++;
              $display("FAIL progress: no instruction consumed for %0d cycles, required < 150", idle);
            end
          end
          hv  = d_valid && d_stall;
          hpc = d_pc;
          hin = d_instr;
        end else begin
          hv = 0;
          idle = 0;
        end
      end
    end
  end

  initial begin
    int unsigned t;
    exp_q.push_back(32'hBFC0_0000);
    repeat (3) @(negedge clk);
    #1;
    check("rst_ireq_valid", {31'b0, ireq_valid}, 32'h0);
    check("rst_d_valid", {31'b0, d_valid}, 32'h0);
    check("rst_d_pc", d_pc, 32'h0);
    check("rst_d_instr", d_instr, 32'h0);

    @(posedge clk);
    #2;
    resetn = 1'b1;
    bus_en = 1;
    dec_en = 1;
    mon_en = 1;
    @(negedge clk);
    #1;
    check("first_req_valid", {31'b0, ireq_valid}, 32'h1);
    check("first_req_addr", ireq_addr, 32'hBFC0_0000);
    @(negedge clk);
    #1;
    check("second_req_addr", ireq_addr, 32'hBFC0_0004);
    check("latency_d_valid", {31'b0, d_valid}, 32'h1);
    check("latency_d_pc", d_pc, 32'hBFC0_0000);

    for (int p = 0; p < 4; p++) begin
      @(posedge clk);
      #2;
      p_addr_ok = ph_ok[p];
      min_lat   = ph_min[p];
      max_lat   = ph_max[p];
      p_stall   = ph_stall[p];
      p_redir   = ph_redir[p];
      repeat (300) @(posedge clk);
    end

    // Reset while a request is outstanding; its late response must be ignored.
    @(posedge clk);
    #2;
    p_addr_ok = 100;
    min_lat   = 4;
    max_lat   = 4;
    p_stall   = 0;
    p_redir   = 0;
    t = 0;
    while (!(bus_busy && bus_cnt == 3) && t < 200) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("rst_wait_outstanding", {31'b0, bus_busy}, 32'h1);
    resetn    = 1'b0;
    bus_stale = 1;
    dec_en    = 0;
    mon_en    = 0;
    @(posedge clk);
    #2;
    exp_q.delete();
    exp_q.push_back(32'hBFC0_0000);
    arch_pc = 32'hBFC0_0000;
    in_slot = 0;
    resetn  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("stale_d_valid", {31'b0, d_valid}, 32'h0);
    end
    @(negedge clk);
    #1;
    check("stale_ignored", {31'b0, d_valid}, 32'h0);
    check("restart_req_valid", {31'b0, ireq_valid}, 32'h1);
    check("restart_req_addr", ireq_addr, 32'hBFC0_0000);
    check("restart_accepted", {31'b0, iresp_addr_ok}, 32'h1);
    dec_en = 1;
    mon_en = 1;

    @(posedge clk);
    #2;
    p_addr_ok = ph_ok[1];
    min_lat   = ph_min[1];
    max_lat   = ph_max[1];
    p_stall   = ph_stall[1];
    p_redir   = ph_redir[1];
    repeat (300) @(posedge clk);
    #2;
    check("consumed_enough", {31'b0, consumed >= 300}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
